// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial RAM port controller (mem_ctrl).
// Optional sign extension of byte/half loads is enabled by defining MEMCTRL_SIGNEXT_EN.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    MC_IDLE    = 3'd0,
    MC_RD      = 3'd1,
    MC_RD_TAIL = 3'd2,
    MC_WR      = 3'd3,
    MC_DONE    = 3'd4
  } mc_state_t;

  localparam logic [1:0]  SZ_B     = 2'b00;
  localparam logic [1:0]  SZ_H     = 2'b01;
  localparam logic [1:0]  SZ_W     = 2'b10;
  localparam logic        Enable   = 1'b1;
  localparam logic        Disable  = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Index of the last byte of a transfer; size code 11 behaves as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SZ_B:    last_idx = 2'd0;
      SZ_H:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_fsm.sv
// Sequencing core of mem_ctrl: state, byte counter and MEM-side RAM address.
// Behaviour is identical with or without MEMCTRL_SIGNEXT_EN.
module mem_ctrl_fsm
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] base,
  output mc_state_t         state,
  output logic [1:0]        cnt,
  output logic              accept,
  output logic [ADDR_W-1:0] mem_addr
);

  mc_state_t         state_n;
  logic [1:0]        cnt_n;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] base_q;
  logic              at_last;

  assign at_last  = (cnt == last_idx(size_q));
  // Wraps naturally at 2^ADDR_W; RD_TAIL reuses the last RD address since cnt stops there.
  assign mem_addr = base_q + {{(ADDR_W-2){1'b0}}, cnt};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = Disable;
    case (state)
      MC_IDLE: begin
        if (req && rdy) begin
          accept  = Enable;
          cnt_n   = 2'd0;
          state_n = wr ? MC_WR : MC_RD;
        end
      end
      MC_RD: begin
        if (at_last) state_n = MC_RD_TAIL;
        else         cnt_n   = cnt + 2'd1;
      end
      MC_RD_TAIL: state_n = MC_DONE;
      MC_WR: begin
        if (at_last) state_n = MC_DONE;
        else         cnt_n   = cnt + 2'd1;
      end
      MC_DONE: state_n = MC_IDLE;
      default: state_n = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= MC_IDLE;
      cnt    <= 2'd0;
      size_q <= SZ_B;
      base_q <= '0;
    end else if (rdy) begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        size_q <= size;
        base_q <= base;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM port owner arbitrating IF fetch against MEM loads/stores (MEM wins).
// Define MEMCTRL_SIGNEXT_EN to add signed_MEM_i and sign-extend 1B/2B loads.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] addr_IF_i,
  output logic [7:0]        data_IF_o,
  output logic              stall_IF_o,
  input  logic              req_MEM_i,
  input  logic              wr_MEM_i,
  input  logic [1:0]        size_MEM_i,
  input  logic [ADDR_W-1:0] addr_MEM_i,
  input  logic [31:0]       wdata_MEM_i,
`ifdef MEMCTRL_SIGNEXT_EN
  input  logic              signed_MEM_i,
`endif
  output logic [31:0]       rdata_MEM_o,
  output logic              done_MEM_o,
  output logic [ADDR_W-1:0] addr_RAM_o,
  input  logic [7:0]        data_RAM_i,
  output logic [7:0]        data_RAM_o,
  output logic              wr_RAM_o,
  output mc_state_t         dbg_state
);

  // Handshake: req_MEM_i is a level the requester holds until it sees done_MEM_o.
  // It is sampled only in IDLE with rdy high; done_MEM_o is a single pulse, after which
  // the requester drops req_MEM_i (or re-presents it, accepted again from IDLE).

  generate
    if (RD_LAT != 1) begin : g_rd_lat_check
      $error("mem_ctrl: only RD_LAT == 1 is supported");
    end
  endgenerate

  mc_state_t         state;
  logic [1:0]        cnt;
  logic              accept;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rdata_n;
  logic [1:0]        rd_idx;
  logic [7:0]        rd_byte;
  logic              rdy_q;
  logic [7:0]        saved_byte;
`ifdef MEMCTRL_SIGNEXT_EN
  logic              sext_b_q;
  logic              sext_h_q;
`endif

  mem_ctrl_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .req      (req_MEM_i),
    .wr       (wr_MEM_i),
    .size     (size_MEM_i),
    .base     (addr_MEM_i),
    .state    (state),
    .cnt      (cnt),
    .accept   (accept),
    .mem_addr (mem_addr)
  );

  assign dbg_state   = state;
  assign data_IF_o   = data_RAM_i;
  assign stall_IF_o  = (state != MC_IDLE) | req_MEM_i;
  assign addr_RAM_o  = (state == MC_IDLE) ? addr_IF_i : mem_addr;
  assign wr_RAM_o    = (state == MC_WR) & rdy;
  assign data_RAM_o  = (state == MC_WR) ? wdata_q[{cnt, 3'b000} +: 8] : 8'h00;
  assign done_MEM_o  = (state == MC_DONE);
  assign rdata_MEM_o = rdata_q;

  // After a freeze the RAM has been re-reading the held address, so the byte for the
  // previous address was parked in saved_byte on the first frozen edge.
  assign rd_idx  = cnt - 2'd1;
  assign rd_byte = rdy_q ? data_RAM_i : saved_byte;

  always_comb begin
    rdata_n = rdata_q;
    if (state == MC_RD && cnt != 2'd0) begin
      rdata_n[{rd_idx, 3'b000} +: 8] = rd_byte;
    end else if (state == MC_RD_TAIL) begin
      rdata_n[{cnt, 3'b000} +: 8] = data_RAM_i;
`ifdef MEMCTRL_SIGNEXT_EN
      if (sext_b_q)      rdata_n = {{24{data_RAM_i[7]}}, data_RAM_i};
      else if (sext_h_q) rdata_n = {{16{data_RAM_i[7]}}, data_RAM_i, rdata_q[7:0]};
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q      <= Enable;
      saved_byte <= 8'h00;
    end else begin
      rdy_q <= rdy;
      if (!rdy && rdy_q) saved_byte <= data_RAM_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= ZeroWord;
      wdata_q <= ZeroWord;
`ifdef MEMCTRL_SIGNEXT_EN
      sext_b_q <= Disable;
      sext_h_q <= Disable;
`endif
    end else if (rdy) begin
      if (accept) begin
        wdata_q <= wdata_MEM_i;
        if (!wr_MEM_i) rdata_q <= ZeroWord;
`ifdef MEMCTRL_SIGNEXT_EN
        sext_b_q <= signed_MEM_i & (size_MEM_i == SZ_B);
        sext_h_q <= signed_MEM_i & (size_MEM_i == SZ_H);
`endif
      end else begin
        rdata_q <= rdata_n;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl with a byte RAM model and a load-result scoreboard.
// Expectations for signed loads follow MEMCTRL_SIGNEXT_EN when it is defined.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rdy = 1'b1;
  logic [ADDR_W-1:0] addr_IF_i = 32'h0000_0123;
  logic [7:0]        data_IF_o;
  logic              stall_IF_o;
  logic              req_MEM_i = 1'b0;
  logic              wr_MEM_i = 1'b0;
  logic [1:0]        size_MEM_i = 2'b00;
  logic [ADDR_W-1:0] addr_MEM_i = '0;
  logic [31:0]       wdata_MEM_i = '0;
`ifdef MEMCTRL_SIGNEXT_EN
  logic              signed_MEM_i = 1'b0;
`endif
  logic [31:0]       rdata_MEM_o;
  logic              done_MEM_o;
  logic [ADDR_W-1:0] addr_RAM_o;
  logic [7:0]        data_RAM_i = 8'h00;
  logic [7:0]        data_RAM_o;
  logic              wr_RAM_o;
  mc_state_t         dbg_state;

  // Clock / reset
  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .addr_IF_i   (addr_IF_i),
    .data_IF_o   (data_IF_o),
    .stall_IF_o  (stall_IF_o),
    .req_MEM_i   (req_MEM_i),
    .wr_MEM_i    (wr_MEM_i),
    .size_MEM_i  (size_MEM_i),
    .addr_MEM_i  (addr_MEM_i),
    .wdata_MEM_i (wdata_MEM_i),
`ifdef MEMCTRL_SIGNEXT_EN
    .signed_MEM_i(signed_MEM_i),
`endif
    .rdata_MEM_o (rdata_MEM_o),
    .done_MEM_o  (done_MEM_o),
    .addr_RAM_o  (addr_RAM_o),
    .data_RAM_i  (data_RAM_i),
    .data_RAM_o  (data_RAM_o),
    .wr_RAM_o    (wr_RAM_o),
    .dbg_state   (dbg_state)
  );

  // External RAM: 4 KiB image, one-cycle read latency, bench preload port.
  logic [7:0]  ram    [0:4095];
  logic [7:0]  shadow [0:4095];
  logic        tb_we    = 1'b0;
  logic [11:0] tb_waddr = '0;
  logic [7:0]  tb_wdata = '0;

  always @(posedge clk) begin
    data_RAM_i <= ram[addr_RAM_o[11:0]];
    if (wr_RAM_o)   ram[addr_RAM_o[11:0]] <= data_RAM_o;
    else if (tb_we) ram[tb_waddr] <= tb_wdata;
  end

  // Scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'h0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    tb_we    = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    shadow[a] = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input int n);
    logic [31:0] r;
    logic [31:0] ai;
    r = 32'h0;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      r[8*i +: 8] = shadow[ai[11:0]];
    end
    return r;
  endfunction

  // Drives one MEM transaction; stall_at > 0 pulls rdy low for 3 edges after that cycle.
  task automatic mem_op(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic sgn, input int stall_at);
    int          n;
    int          lat;
    int          nwr;
    int          exp_lat;
    logic [31:0] ev;
    logic [31:0] ai;
    string       tag;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    tag = wr ? $sformatf("st%0d@%h", n, a) : $sformatf("ld%0d%s@%h", n, sgn ? "s" : "u", a);
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        ai = a + 32'(i);
        shadow[ai[11:0]] = wd[8*i +: 8];
      end
      exp_q.push_back(last_rd);
    end else begin
      ev = model_load(a, n);
`ifdef MEMCTRL_SIGNEXT_EN
      if (sgn && n == 1)      ev = {{24{ev[7]}}, ev[7:0]};
      else if (sgn && n == 2) ev = {{16{ev[15]}}, ev[15:0]};
`endif
      last_rd = ev;
      exp_q.push_back(ev);
    end
    exp_lat = (wr ? n + 1 : n + 2) + ((stall_at > 0) ? 3 : 0);

    @(posedge clk);
    #1;
    req_MEM_i   = 1'b1;
    wr_MEM_i    = wr;
    size_MEM_i  = sz;
    addr_MEM_i  = a;
    wdata_MEM_i = wd;
`ifdef MEMCTRL_SIGNEXT_EN
    signed_MEM_i = sgn;
`endif
    @(negedge clk);
    expect_eq({tag, "_stall_req"}, 32'(stall_IF_o), 32'd1);

    lat = 0;
    nwr = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (wr_RAM_o) nwr++;
      if (done_MEM_o) begin
        lat       = c;
        req_MEM_i = 1'b0;
      end
      if (c == stall_at) rdy = 1'b0;
      if (stall_at > 0 && c == stall_at + 3) rdy = 1'b1;
    end
    rdy = 1'b1;
    expect_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (lat != 0) begin
      expect_eq({tag, "_rdata"}, rdata_MEM_o, exp_q.pop_front());
      @(negedge clk);
      expect_eq({tag, "_done_width"}, 32'(done_MEM_o), 32'd0);
    end else begin
      req_MEM_i = 1'b0;
      void'(exp_q.pop_front());
    end
    expect_eq({tag, "_writes"}, 32'(nwr), wr ? 32'(n) : 32'd0);
  endtask

  initial begin
    int          done_seen;
    logic [1:0]  rsz;
    logic [31:0] ra;
    logic [31:0] rw;

    // Reset phase with RAM preload
    poke(12'h100, 8'hAB);
    poke(12'h200, 8'h11);
    poke(12'h201, 8'h22);
    poke(12'h202, 8'h33);
    poke(12'h203, 8'h44);
    poke(12'h300, 8'h80);
    poke(12'hFFF, 8'h5C);
    poke(12'h000, 8'hA7);
    @(negedge clk);
    expect_eq("rst_state", 32'(dbg_state), 32'(MC_IDLE));
    expect_eq("rst_done", 32'(done_MEM_o), 32'd0);
    expect_eq("rst_rdata", rdata_MEM_o, 32'h0);
    expect_eq("rst_wr", 32'(wr_RAM_o), 32'd0);
    expect_eq("rst_wdata", 32'(data_RAM_o), 32'd0);
    expect_eq("rst_addr_mux", addr_RAM_o, 32'h0000_0123);
    @(posedge clk);
    #1 rst = 1'b1;

    // Idle fetch
    @(posedge clk);
    #1 addr_IF_i = 32'h0000_0100;
    @(negedge clk);
    expect_eq("if_addr", addr_RAM_o, 32'h0000_0100);
    expect_eq("if_stall", 32'(stall_IF_o), 32'd0);
    @(negedge clk);
    expect_eq("if_data", 32'(data_IF_o), 32'h0000_00AB);

    // Directed MEM traffic
    mem_op(1'b0, SZ_W, 32'h0000_0200, 32'h0, 1'b0, 0);
    expect_eq("word_load_value", rdata_MEM_o, 32'h4433_2211);
    mem_op(1'b1, SZ_H, 32'h0000_03FF, 32'h0000_BEEF, 1'b0, 0);
    expect_eq("half_store_lo", 32'(ram[12'h3FF]), 32'h0000_00EF);
    expect_eq("half_store_hi", 32'(ram[12'h400]), 32'h0000_00BE);
    mem_op(1'b0, SZ_W, 32'h0000_0200, 32'h0, 1'b0, 2);
    expect_eq("stalled_load_value", rdata_MEM_o, 32'h4433_2211);
    mem_op(1'b0, SZ_B, 32'h0000_0300, 32'h0, 1'b1, 0);
    mem_op(1'b0, SZ_B, 32'h0000_0300, 32'h0, 1'b0, 0);
    mem_op(1'b0, SZ_H, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
    mem_op(1'b0, 2'b11, 32'h0000_0200, 32'h0, 1'b0, 0);
    mem_op(1'b0, SZ_H, 32'h0000_03FF, 32'h0, 1'b0, 0);

    // Reset in the middle of a word store
    @(posedge clk);
    #1;
    req_MEM_i   = 1'b1;
    wr_MEM_i    = 1'b1;
    size_MEM_i  = SZ_W;
    addr_MEM_i  = 32'h0000_0500;
    wdata_MEM_i = 32'hA1B2_C3D4;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    expect_eq("abort_pre_wr", 32'(wr_RAM_o), 32'd1);
    rst       = 1'b0;
    req_MEM_i = 1'b0;
    #1;
    expect_eq("abort_wr", 32'(wr_RAM_o), 32'd0);
    expect_eq("abort_stall", 32'(stall_IF_o), 32'd0);
    expect_eq("abort_state", 32'(dbg_state), 32'(MC_IDLE));
    expect_eq("abort_rdata", rdata_MEM_o, 32'h0);
    last_rd   = 32'h0;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done_MEM_o) done_seen++;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done_MEM_o) done_seen++;
    end
    expect_eq("abort_no_done", 32'(done_seen), 32'd0);

    // Random store then read-back pairs
    for (int i = 0; i < 8; i++) begin
      rsz = 2'($urandom_range(0, 3));
      ra  = 32'h0000_0600 + 32'($urandom_range(0, 64));
      rw  = $urandom;
      mem_op(1'b1, rsz, ra, rw, 1'b0, 0);
      mem_op(1'b0, rsz, ra, 32'h0, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? 1 : 0);
    end

    expect_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
